// File: rtl/axi4_lite_result_fifo.sv
// Capture FIFO for the adder result, drained by the SoC over an AXI4-Lite slave port.
// Capture is gated by CTRL.enable and qualified by sample_en (mode 0) or by a change of result_in (mode 1).
module axi4_lite_result_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic [31:0]       S_AXI_AWADDR,
    input  logic [2:0]        S_AXI_AWPROT,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [31:0]       S_AXI_ARADDR,
    input  logic [2:0]        S_AXI_ARPROT,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    input  logic [DATA_W-1:0] result_in,
    input  logic              sample_en
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic              awready_r;
    logic              bvalid_r;
    logic              arready_r;
    logic              rvalid_r;
    logic [31:0]       rdata_r;
    logic              enable_r;
    logic              mode_r;
    logic              overflow_r;
    logic [DATA_W-1:0] last_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              aw_hs_s;
    logic              ar_hs_s;
    logic              ctrl_wr_s;
    logic              flush_s;
    logic              empty_s;
    logic              full_s;
    logic              pop_s;
    logic              capture_s;
    logic              push_s;
    logic [31:0]       rd_word_s;
    logic              unused_s;

    assign aw_hs_s   = awready_r & S_AXI_AWVALID & S_AXI_WVALID;
    assign ar_hs_s   = arready_r & S_AXI_ARVALID;
    assign ctrl_wr_s = aw_hs_s & (S_AXI_AWADDR[3:2] == 2'd2) & S_AXI_WSTRB[0];
    assign flush_s   = ctrl_wr_s & S_AXI_WDATA[2];
    assign empty_s   = (count_r == CW'(0));
    assign full_s    = (count_r == CW'(DEPTH));
    assign pop_s     = ar_hs_s & (S_AXI_ARADDR[3:2] == 2'd0) & ~empty_s;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the sample.
    assign push_s    = capture_s & (~full_s | pop_s);

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = awready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = 2'b00;

    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[31:4], S_AXI_AWADDR[1:0],
                        S_AXI_ARADDR[31:4], S_AXI_ARADDR[1:0], S_AXI_WDATA[31:3], S_AXI_WSTRB[3:1]};

    // Capture qualification for the current cycle.
    always_comb begin
        capture_s = 1'b0;
        if (enable_r) begin
            if (mode_r) begin
                capture_s = (result_in != last_r);
            end else begin
                capture_s = sample_en;
            end
        end else begin
            capture_s = 1'b0;
        end
    end

    // Read data mux, sampled into rdata_r on the read accept edge.
    always_comb begin
        rd_word_s = 32'd0;
        case (S_AXI_ARADDR[3:2])
            2'd0: begin
                if (!empty_s) begin
                    rd_word_s[DATA_W-1:0] = mem_r[rd_ptr_r];
                    rd_word_s[31]         = 1'b1;
                end else begin
                    rd_word_s = 32'd0;
                end
            end
            2'd1: begin
                rd_word_s[0]    = empty_s;
                rd_word_s[1]    = full_s;
                rd_word_s[2]    = overflow_r;
                rd_word_s[16:8] = 9'(count_r);
            end
            2'd2:    rd_word_s[1:0] = {mode_r, enable_r};
            default: rd_word_s = 32'd0;
        endcase
    end

    // AXI handshakes: single outstanding read and write, one-cycle ready pulses.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_r <= 1'b0;
            bvalid_r  <= 1'b0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'd0;
        end else begin
            awready_r <= ~awready_r & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_r;
            if (aw_hs_s) begin
                bvalid_r <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid_r <= 1'b0;
            end
            arready_r <= ~arready_r & S_AXI_ARVALID & ~rvalid_r;
            if (ar_hs_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_word_s;
            end else if (S_AXI_RREADY) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // Control register, capture history, FIFO pointers and occupancy; flush overrides push and pop.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            enable_r   <= 1'b0;
            mode_r     <= 1'b0;
            overflow_r <= 1'b0;
            last_r     <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
        end else begin
            if (ctrl_wr_s) begin
                enable_r <= S_AXI_WDATA[0];
                mode_r   <= S_AXI_WDATA[1];
            end
            if (flush_s) begin
                overflow_r <= 1'b0;
                last_r     <= '0;
                wr_ptr_r   <= '0;
                rd_ptr_r   <= '0;
                count_r    <= '0;
            end else begin
                if (capture_s) begin
                    last_r <= result_in;
                end
                if (capture_s && full_s && !pop_s) begin
                    overflow_r <= 1'b1;
                end
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CW'(1);
                    2'b01:   count_r <= count_r - CW'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge S_AXI_ACLK) begin
        if (push_s && !flush_s) begin
            mem_r[wr_ptr_r] <= result_in;
        end
    end
endmodule

// File: tb/tb_axi4_lite_result_fifo.sv
// Self-checking bench for axi4_lite_result_fifo: register table, directed capture sequences,
// and randomized traffic against a queue-based reference model.
module tb_axi4_lite_result_fifo;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       S_AXI_AWADDR = 32'd0;
    logic [2:0]        S_AXI_AWPROT = 3'd0;
    logic              S_AXI_AWVALID = 1'b0;
    logic              S_AXI_AWREADY;
    logic [31:0]       S_AXI_WDATA = 32'd0;
    logic [3:0]        S_AXI_WSTRB = 4'd0;
    logic              S_AXI_WVALID = 1'b0;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY = 1'b0;
    logic [31:0]       S_AXI_ARADDR = 32'd0;
    logic [2:0]        S_AXI_ARPROT = 3'd0;
    logic              S_AXI_ARVALID = 1'b0;
    logic              S_AXI_ARREADY;
    logic [31:0]       S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY = 1'b0;
    logic [DATA_W-1:0] result_in = '0;
    logic              sample_en = 1'b0;

    always #5 clk = ~clk;

    axi4_lite_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .result_in(result_in), .sample_en(sample_en)
    );

    int          checks = 0;
    int          errors = 0;
    int          ticks  = 0;
    int          q[$];
    bit          m_en, m_mode, m_ovf;
    int          m_last;
    logic [31:0] exp_rdata = 32'd0;
    bit          rand_mode = 1'b0;
    bit          cap_on_accept = 1'b0;
    logic [31:0] d;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_en = 1'b0; m_mode = 1'b0; m_ovf = 1'b0; m_last = 0;
    endtask

    // Predicts the effect of the next rising edge from the inputs and handshake state seen now.
    task automatic model_step();
        bit rd_acc, wr_acc, ctrl_wr, pop, flush, cond;
        int res, n;
        rd_acc  = S_AXI_ARREADY && S_AXI_ARVALID;
        wr_acc  = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
        ctrl_wr = wr_acc && (S_AXI_AWADDR[3:2] == 2'd2) && S_AXI_WSTRB[0];
        flush   = ctrl_wr && S_AXI_WDATA[2];
        res     = int'(result_in);
        pop     = 1'b0;
        n       = q.size();
        if (rd_acc) begin
            case (S_AXI_ARADDR[3:2])
                2'd0: begin
                    if (n > 0) begin
                        exp_rdata = 32'h8000_0000 + 32'(q[0]);
                        pop = 1'b1;
                    end else begin
                        exp_rdata = 32'd0;
                    end
                end
                2'd1: exp_rdata = 32'(n * 256 + (m_ovf ? 4 : 0) + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0));
                2'd2: exp_rdata = 32'((m_mode ? 2 : 0) + (m_en ? 1 : 0));
                default: exp_rdata = 32'd0;
            endcase
        end
        cond = m_en && (m_mode ? (res != m_last) : (sample_en == 1'b1));
        if (flush) begin
            q.delete();
            m_ovf = 1'b0;
            m_last = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (cond) begin
                m_last = res;
                if (q.size() < DEPTH) q.push_back(res);
                else m_ovf = 1'b1;
            end
        end
        if (ctrl_wr) begin
            m_en = S_AXI_WDATA[0];
            m_mode = S_AXI_WDATA[1];
        end
    endtask

    task automatic tick();
        if (rand_mode) begin
            sample_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) result_in = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
        end
        model_step();
        @(negedge clk);
        ticks++;
        if (ticks > 60000) begin
            $display("FAIL watchdog actual=%0d cycles expected=<60000", ticks);
            $fatal(1, "watchdog expired");
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int hold);
        int n;
        n = 0;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        while (!S_AXI_AWREADY && n < 20) begin tick(); n++; end
        if (!S_AXI_AWREADY) begin
            check("aw_timeout", 32'(S_AXI_AWREADY), 32'd1);
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
            return;
        end
        check("wready_with_awready", 32'(S_AXI_WREADY), 32'd1);
        tick();
        S_AXI_AWVALID = (hold > 0); S_AXI_WVALID = (hold > 0);
        check("bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("bresp", 32'(S_AXI_BRESP), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
            check("awready_hold", 32'(S_AXI_AWREADY), 32'd0);
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("bvalid_clr", 32'(S_AXI_BVALID), 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold, output logic [31:0] data);
        int n;
        n = 0;
        data = 32'd0;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        while (!S_AXI_ARREADY && n < 20) begin tick(); n++; end
        if (!S_AXI_ARREADY) begin
            check("ar_timeout", 32'(S_AXI_ARREADY), 32'd1);
            S_AXI_ARVALID = 1'b0;
            return;
        end
        if (cap_on_accept) sample_en = 1'b1;
        tick();
        if (cap_on_accept) sample_en = 1'b0;
        S_AXI_ARVALID = (hold > 0);
        check("rvalid", 32'(S_AXI_RVALID), 32'd1);
        check("rdata_model", S_AXI_RDATA, exp_rdata);
        check("rresp", 32'(S_AXI_RRESP), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
            check("rdata_hold", S_AXI_RDATA, exp_rdata);
            check("arready_hold", 32'(S_AXI_ARREADY), 32'd0);
        end
        data = S_AXI_RDATA;
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        check("rvalid_clr", 32'(S_AXI_RVALID), 32'd0);
    endtask

    task automatic rd_exp(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        axi_read(addr, 0, v);
        check(name, v, exp);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("rst_wready", 32'(S_AXI_WREADY), 32'd0);
        check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check("rst_rdata", S_AXI_RDATA, 32'd0);
        check("rst_resp", {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Register map table: reset values, reserved slot, WSTRB gating, self-clearing flush bit.
        vecs.push_back('{1'b0, 32'h4, 32'h0,         4'h0, 32'h0000_0001});
        vecs.push_back('{1'b0, 32'h0, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h8, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'hC, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{1'b1, 32'hC, 32'hFFFF_FFFF, 4'hF, 32'h0});
        vecs.push_back('{1'b0, 32'hC, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h8, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{1'b1, 32'h8, 32'h3,         4'hE, 32'h0});
        vecs.push_back('{1'b0, 32'h8, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{1'b1, 32'h8, 32'h7,         4'h1, 32'h0});
        vecs.push_back('{1'b0, 32'h8, 32'h0,         4'h0, 32'h0000_0003});
        vecs.push_back('{1'b0, 32'h4, 32'h0,         4'h0, 32'h0000_0001});
        vecs.push_back('{1'b1, 32'h8, 32'h0,         4'h1, 32'h0});
        vecs.push_back('{1'b0, 32'h8, 32'h0,         4'h0, 32'h0000_0000});
        foreach (vecs[i]) begin
            if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, 0);
            else rd_exp($sformatf("table_%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Mode 0: three strobed samples, then drained in order.
        axi_write(32'h8, 32'h1, 4'h1, 0);
        sample_en = 1'b1;
        result_in = 4'h3; tick();
        result_in = 4'h7; tick();
        result_in = 4'hF; tick();
        sample_en = 1'b0;
        rd_exp("m0_status", 32'h4, 32'h0000_0300);
        rd_exp("m0_data0", 32'h0, 32'h8000_0003);
        rd_exp("m0_data1", 32'h0, 32'h8000_0007);
        rd_exp("m0_data2", 32'h0, 32'h8000_000F);
        rd_exp("m0_empty", 32'h0, 32'h0000_0000);

        // Mode 1 after flush: a held value captures once, a change captures again.
        result_in = 4'h0;
        axi_write(32'h8, 32'h7, 4'h1, 0);
        result_in = 4'h5;
        repeat (10) tick();
        result_in = 4'h6;
        repeat (3) tick();
        axi_write(32'h8, 32'h0, 4'h1, 0);
        rd_exp("m1_status", 32'h4, 32'h0000_0200);
        rd_exp("m1_data0", 32'h0, 32'h8000_0005);
        rd_exp("m1_data1", 32'h0, 32'h8000_0006);

        // Overfill by two: full and sticky overflow, oldest sixteen retained.
        axi_write(32'h8, 32'h5, 4'h1, 0);
        sample_en = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin result_in = DATA_W'(i); tick(); end
        sample_en = 1'b0;
        rd_exp("full_status", 32'h4, 32'h0000_1006);
        for (int i = 0; i < DEPTH; i++) rd_exp($sformatf("full_data%0d", i), 32'h0, 32'h8000_0000 + 32'(i));
        rd_exp("drained_status", 32'h4, 32'h0000_0005);
        sample_en = 1'b1;
        repeat (4) tick();
        sample_en = 1'b0;
        axi_write(32'h8, 32'h5, 4'h1, 0);
        rd_exp("flush_status", 32'h4, 32'h0000_0001);

        // Full FIFO: capture coincides with the pop of a DATA read.
        sample_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin result_in = DATA_W'(DEPTH - 1 - i); tick(); end
        sample_en = 1'b0;
        rd_exp("coinc_pre", 32'h4, 32'h0000_1002);
        result_in = 4'hA;
        cap_on_accept = 1'b1;
        rd_exp("coinc_pop", 32'h0, 32'h8000_000F);
        cap_on_accept = 1'b0;
        rd_exp("coinc_post", 32'h4, 32'h0000_1002);
        for (int i = 0; i < DEPTH - 1; i++) rd_exp($sformatf("coinc_data%0d", i), 32'h0, 32'h8000_000E - 32'(i));
        rd_exp("coinc_last", 32'h0, 32'h8000_000A);
        axi_write(32'h8, 32'h4, 4'h1, 0);

        // Back-pressure on both response channels.
        axi_write(32'h8, 32'h1, 4'h1, 5);
        axi_read(32'h8, 5, d);
        check("hold_ctrl", d, 32'h0000_0001);

        // Reset while a read response is pending.
        S_AXI_ARADDR = 32'h4; S_AXI_ARVALID = 1'b1;
        for (int n = 0; n < 20 && !S_AXI_ARREADY; n++) tick();
        tick();
        S_AXI_ARVALID = 1'b0;
        check("pre_rst_rvalid", 32'(S_AXI_RVALID), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check("mid_rst_rdata", S_AXI_RDATA, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_exp("post_rst_status", 32'h4, 32'h0000_0001);
        rd_exp("post_rst_ctrl", 32'h8, 32'h0000_0000);

        // Randomized traffic checked against the reference model.
        axi_write(32'h8, 32'h1, 4'h1, 0);
        rand_mode = 1'b1;
        for (int i = 0; i < 250; i++) begin
            int op;
            logic [31:0] wv;
            op = $urandom_range(0, 11);
            if (op < 5) axi_read(32'h0, 0, d);
            else if (op < 8) axi_read(32'h4, 0, d);
            else if (op < 9) axi_read(32'h8, 0, d);
            else if (op < 11) repeat ($urandom_range(1, 4)) tick();
            else begin
                wv = 32'($urandom_range(0, 7));
                if ($urandom_range(0, 3) != 0) wv[2] = 1'b0;
                if ($urandom_range(0, 3) != 0) wv[0] = 1'b1;
                axi_write(32'h8, wv, 4'h1, 0);
            end
        end
        rand_mode = 1'b0;
        sample_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
